result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Parametrised successor to the fixed 8-slot result selection used between functional units and write-back.
- Collects results from NUM_CH functional-unit channels, each with its own valid/ready handshake.
- Buffers each channel in a small FIFO and arbitrates one result per cycle into a registered write-back port.
- Sits between the FU bank and GPR write-back; removes FU stalls when several units finish in the same cycle.

Parameters:
- NUM_CH, 8, number of FU result channels (2..16).
- DEPTH, 2, entries per channel FIFO (power of 2, >=2).
- DATA_W, 32, result data width.
- DEST_W, 5, GPR destination address width.
- ARB_MODE, ARB_RR, arbitration mode: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered and staged results.
- in_valid  in  NUM_CH  per-channel result valid.
- in_ready  out  NUM_CH  per-channel accept (= FIFO not full).
- in_dest  in  NUM_CH*DEST_W  per-channel destination GPR, channel i at [i*DEST_W +: DEST_W].
- in_data  in  NUM_CH*DATA_W  per-channel result data, same packing.
- wb_valid  out  1  write-back result valid.
- wb_ready  in  1  write-back sink accepts.
- wb_dest  out  DEST_W  destination GPR.
- wb_data  out  DATA_W  result data.
- wb_ch  out  $clog2(NUM_CH)  originating channel.
- busy  out  1  any FIFO or the output register is occupied.

Behaviour:
- Reset (reset=0, async): all FIFOs empty, in_ready all 1, wb_valid=0, wb_dest/wb_data/wb_ch=0, busy=0, RR pointer=0.
- Push: channel i writes when in_valid[i]&in_ready[i]. in_ready[i]=!full[i] depends only on registered state; no same-cycle pop-through when full.
- Output register loads when (!wb_valid | wb_ready) and at least one FIFO is non-empty. The granted FIFO pops in the same cycle.
- Hold: wb_valid & !wb_ready holds wb_* stable and grants nothing.
- Latency: accepted in cycle 0, uncontended, gives wb_valid in cycle 2. Sustained throughput is 1 result/cycle.
- ARB_FIXED: grant = lowest-index non-empty channel.
- ARB_RR: search starts at the pointer and wraps modulo NUM_CH. After a grant to channel g, pointer=(g+1) mod NUM_CH. With no grant the pointer is unchanged.
- Per-channel order is preserved (FIFO). There is no ordering guarantee across channels.
- FIFO pointers are $clog2(DEPTH)+1 bits with a wrap bit. full = pointers equal except the MSB; empty = pointers equal.
- Push and pop on the same non-full, non-empty FIFO in one cycle: occupancy unchanged.
- Flush (synchronous, highest priority): at the next edge all FIFOs are emptied and wb_valid=0. Pushes and the grant in the flush cycle are dropped; the RR pointer resets to 0. wb_valid may be 1 during the flush cycle, and the sink must ignore it.
- busy = |(~empty) | wb_valid.
- No overflow is possible through the handshake. An assertion flags a push to a full FIFO.

Decomposition:
- Backend package: Arb_mode enum {ARB_RR, ARB_FIXED}; a function computing the rotate-priority grant index.
- Sub-module result_fifo (DEPTH, WIDTH=DEST_W+DATA_W): push, pop, flush, full, empty, head. Instantiated NUM_CH times via generate.
- Top level holds the arbiter, RR pointer, output register and handshake logic.

Test Plan:
- Reset then single push: ch3 dest=5 data=0xDEADBEEF in cycle 0 -> wb_valid=1 in cycle 2 with wb_ch=3, wb_dest=5, wb_data=0xDEADBEEF; busy=0 after the pop with wb_ready=1.
- All 8 channels push in one cycle, ARB_RR, wb_ready=1 -> wb_ch sequence 0,1,...,7 on consecutive cycles, no gaps. Repeat from pointer=5 -> 5,6,7,0,...,4.
- ARB_FIXED, ch1 and ch6 push continuously -> only ch1 is granted; in_ready[6]=0 after 2 accepts (DEPTH=2).
- Backpressure: wb_ready=0 for 4 cycles with ch2 pushing 0x1,0x2,0x3 -> wb_data holds 0x1; in_ready[2]=0 after FIFO full; release gives 0x1,0x2,0x3 in order.
- Flush with 2 entries buffered and wb_valid=1 -> next cycle wb_valid=0, busy=0, all in_ready=1; a push in the flush cycle never appears.
- Async reset asserted mid-burst (between edges) -> wb_valid=0 immediately; after release, a new push emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared types and helpers for the result collector: arbitration mode and the
// rotate-priority grant search used by both arbitration flavours.
package result_collector_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // The grant helper is sized for the largest supported channel count so one
  // function serves every instance; callers zero-extend their request vector.
  localparam int unsigned MAX_CH = 16;
  localparam int unsigned IDX_W  = 4;

  // First requester found when scanning upward from 'start', wrapping modulo
  // num_ch. Fixed priority is the same search with start = 0. Returns 0 when
  // nothing requests; callers qualify the result with their own OR-reduce.
  function automatic logic [IDX_W-1:0] rotate_grant(
    input logic [MAX_CH-1:0] req,
    input logic [IDX_W-1:0]  start,
    input int unsigned       num_ch
  );
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             hit;
    int unsigned      pos;
    sel = '0;
    idx = '0;
    hit = 1'b0;
    pos = 0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      pos = (32'(start) + k) % num_ch;
      idx = pos[IDX_W-1:0];
      if (!hit && (k < num_ch) && req[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-channel result buffer. Pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer update; flush empties the buffer and overrides any push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  // The handshake upstream is expected to never offer data to a full buffer.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: rtl/result_collector.sv
// Collects results from NUM_CH functional-unit channels, buffers each in a
// small FIFO and arbitrates one result per cycle into a registered
// write-back port.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned  NUM_CH   = 8,
  parameter int unsigned  DEPTH    = 2,
  parameter int unsigned  DATA_W   = 32,
  parameter int unsigned  DEST_W   = 5,
  parameter arb_mode_e    ARB_MODE = ARB_RR,
  localparam int unsigned CH_W     = $clog2(NUM_CH),
  localparam int unsigned ENTRY_W  = DEST_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*DEST_W-1:0]   in_dest,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DEST_W-1:0]          wb_dest,
  output logic [DATA_W-1:0]          wb_data,
  output logic [CH_W-1:0]            wb_ch,
  output logic                       busy
);

  logic [NUM_CH-1:0]  fifo_full;
  logic [NUM_CH-1:0]  fifo_empty;
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  pop;
  logic [ENTRY_W-1:0] head [NUM_CH];

  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    ptr_next;
  logic [CH_W-1:0]    grant_idx;
  logic [MAX_CH-1:0]  req;
  logic [IDX_W-1:0]   search_start;
  logic               any_req;
  logic               can_load;
  logic               grant_vld;
  logic [ENTRY_W-1:0] grant_entry;

  // in_ready comes straight from registered fullness, so a full FIFO never
  // accepts even if it is being popped in the same cycle.
  assign in_ready = ~fifo_full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = in_valid[i] & ~fifo_full[i];

    result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({in_dest[i*DEST_W +: DEST_W], in_data[i*DATA_W +: DATA_W]}),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .head  (head[i])
    );
  end

  // Arbitration: pick a non-empty FIFO whenever the output register can take
  // a new result; nothing is granted while flushing or holding.
  always_comb begin
    req          = MAX_CH'(~fifo_empty);
    search_start = (ARB_MODE == ARB_RR) ? IDX_W'(rr_ptr) : '0;
    grant_idx    = CH_W'(rotate_grant(req, search_start, NUM_CH));
    any_req      = |(~fifo_empty);
    can_load     = ~wb_valid | wb_ready;
    grant_vld    = can_load & any_req & ~flush;
    grant_entry  = head[grant_idx];
    ptr_next     = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  end

  // One-hot pop to the granted FIFO.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = grant_vld && (grant_idx == CH_W'(i));
    end
  end

  // Round-robin pointer moves past the last winner; flush restarts it at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= ptr_next;
    end
  end

  // Write-back register: load on grant, clear once consumed, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      wb_ch    <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (grant_vld) begin
      wb_valid <= 1'b1;
      wb_dest  <= grant_entry[ENTRY_W-1 -: DEST_W];
      wb_data  <= grant_entry[DATA_W-1:0];
      wb_ch    <= grant_idx;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  assign busy = (|(~fifo_empty)) | wb_valid;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: one round-robin and one fixed-priority
// instance. Expected entries are queued per channel at issue time and a
// monitor per instance pops and compares on every write-back handshake.
module tb_result_collector;
  import result_collector_pkg::*;

  localparam int NCH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // round-robin instance
  logic          rr_flush;
  logic [7:0]    rr_valid, rr_rdy;
  logic [39:0]   rr_dest;
  logic [255:0]  rr_data;
  logic          rr_wbv, rr_wbr, rr_busy;
  logic [4:0]    rr_wdest;
  logic [31:0]   rr_wdata;
  logic [2:0]    rr_ch;

  // fixed-priority instance
  logic          fx_flush;
  logic [7:0]    fx_valid, fx_rdy;
  logic [39:0]   fx_dest;
  logic [255:0]  fx_data;
  logic          fx_wbv, fx_wbr, fx_busy;
  logic [4:0]    fx_wdest;
  logic [31:0]   fx_wdata;
  logic [2:0]    fx_ch;

  logic [36:0] rr_q [NCH][$];
  logic [36:0] fx_q [NCH][$];
  logic [36:0] rr_e, fx_e;

  result_collector #(.NUM_CH(8), .DEPTH(2), .DATA_W(32), .DEST_W(5), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .reset(reset), .flush(rr_flush),
    .in_valid(rr_valid), .in_ready(rr_rdy), .in_dest(rr_dest), .in_data(rr_data),
    .wb_valid(rr_wbv), .wb_ready(rr_wbr), .wb_dest(rr_wdest), .wb_data(rr_wdata),
    .wb_ch(rr_ch), .busy(rr_busy)
  );

  result_collector #(.NUM_CH(8), .DEPTH(2), .DATA_W(32), .DEST_W(5), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .reset(reset), .flush(fx_flush),
    .in_valid(fx_valid), .in_ready(fx_rdy), .in_dest(fx_dest), .in_data(fx_data),
    .wb_valid(fx_wbv), .wb_ready(fx_wbr), .wb_dest(fx_wdest), .wb_data(fx_wdata),
    .wb_ch(fx_ch), .busy(fx_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with no expected entry at %0t", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rr_set(input int ch, input logic [4:0] d, input logic [31:0] v);
    rr_valid[ch]       = 1'b1;
    rr_dest[ch*5 +: 5] = d;
    rr_data[ch*32 +: 32] = v;
    if (rr_rdy[ch]) rr_q[ch].push_back({d, v});
  endtask

  task automatic fx_set(input int ch, input logic [4:0] d, input logic [31:0] v);
    fx_valid[ch]       = 1'b1;
    fx_dest[ch*5 +: 5] = d;
    fx_data[ch*32 +: 32] = v;
    if (fx_rdy[ch]) fx_q[ch].push_back({d, v});
  endtask

  task automatic rr_clear_q();
    for (int i = 0; i < NCH; i++) rr_q[i].delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Monitor: compare every accepted write-back against the channel's queue.
  always @(negedge clk) begin
    if (reset && !rr_flush && rr_wbv && rr_wbr) begin
      if (rr_q[rr_ch].size() == 0) fail_msg("rr_unexpected_wb", {rr_ch, rr_wdest, rr_wdata});
      else begin
        rr_e = rr_q[rr_ch].pop_front();
        check("rr_wb_entry", {rr_wdest, rr_wdata}, rr_e);
      end
    end
    if (reset && !fx_flush && fx_wbv && fx_wbr) begin
      if (fx_q[fx_ch].size() == 0) fail_msg("fx_unexpected_wb", {fx_ch, fx_wdest, fx_wdata});
      else begin
        fx_e = fx_q[fx_ch].pop_front();
        check("fx_wb_entry", {fx_wdest, fx_wdata}, fx_e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt6;
    int left;
    reset = 1'b0;
    rr_flush = 1'b0; rr_valid = '0; rr_dest = '0; rr_data = '0; rr_wbr = 1'b1;
    fx_flush = 1'b0; fx_valid = '0; fx_dest = '0; fx_data = '0; fx_wbr = 1'b1;
    #2;
    // reset state
    check("rst_wb_valid", rr_wbv, 0);
    check("rst_in_ready", rr_rdy, 8'hFF);
    check("rst_busy", rr_busy, 0);
    check("rst_wb_fields", {rr_ch, rr_wdest, rr_wdata}, 0);
    check("rst_fx_wb_valid", fx_wbv, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // single push on ch3, two-cycle latency
    rr_set(3, 5'd5, 32'hDEADBEEF);
    tick();
    rr_valid = '0;
    check("lat_cycle1", rr_wbv, 0);
    tick();
    check("lat_cycle2", rr_wbv, 1);
    check("single_ch", rr_ch, 3);
    check("single_dest", rr_wdest, 5);
    check("single_data", rr_wdata, 32'hDEADBEEF);
    tick();
    check("single_busy_after", rr_busy, 0);

    // all channels at once from pointer 0
    do_reset();
    for (int i = 0; i < NCH; i++) rr_set(i, 5'(i + 8), 32'h1000_0000 + 32'(i));
    tick();
    rr_valid = '0;
    tick();
    for (int k = 0; k < NCH; k++) begin
      check("rr0_valid", rr_wbv, 1);
      check("rr0_ch", rr_ch, 64'(k));
      tick();
    end
    check("rr0_done", rr_wbv, 0);

    // move pointer to 5 with a lone ch4 result, then all channels again
    rr_set(4, 5'd20, 32'hC4C4_0000);
    tick();
    rr_valid = '0;
    tick();
    check("rr_ch4", rr_ch, 4);
    tick();
    for (int i = 0; i < NCH; i++) rr_set(i, 5'(i), 32'h2000_0000 + 32'(i));
    tick();
    rr_valid = '0;
    tick();
    for (int k = 0; k < NCH; k++) begin
      check("rr5_valid", rr_wbv, 1);
      check("rr5_ch", rr_ch, 64'((5 + k) % NCH));
      tick();
    end

    // fixed priority: ch1 and ch6 stream continuously, only ch1 wins
    cnt6 = 0;
    for (int c = 0; c < 8; c++) begin
      if (fx_rdy[6]) cnt6++;
      fx_set(1, 5'd1, 32'h0000_0100 + 32'(c));
      fx_set(6, 5'd6, 32'h0000_0600 + 32'(c));
      if (c >= 2) begin
        check("fx_valid", fx_wbv, 1);
        check("fx_only_ch1", fx_ch, 1);
      end
      tick();
    end
    check("fx_ch6_blocked", fx_rdy[6], 0);
    check("fx_ch6_accepts", cnt6, 2);
    check("fx_ch1_ready", fx_rdy[1], 1);
    fx_valid = '0;
    repeat (8) tick();
    check("fx_drained", fx_busy, 0);

    // backpressure on ch2
    rr_wbr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check("bp_ready", rr_rdy[2], 1);
      rr_set(2, 5'd9, 32'(i));
      tick();
    end
    rr_valid = '0;
    check("bp_full", rr_rdy[2], 0);
    repeat (3) begin
      check("bp_hold_valid", rr_wbv, 1);
      check("bp_hold_data", rr_wdata, 1);
      tick();
    end
    rr_wbr = 1'b1;
    repeat (5) tick();
    check("bp_drained", rr_busy, 0);

    // flush with a staged result plus two buffered entries
    rr_wbr = 1'b0;
    for (int i = 0; i < 3; i++) rr_set(0, 5'd1, 32'hF0 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      rr_set(0, 5'd1, 32'hF0 + 32'(i));
      tick();
    end
    rr_valid = '0;
    check("fl_pre_valid", rr_wbv, 1);
    check("fl_pre_full", rr_rdy[0], 0);
    rr_flush = 1'b1;
    rr_valid[5] = 1'b1;
    rr_dest[25 +: 5] = 5'd30;
    rr_data[160 +: 32] = 32'h0000_0BAD;
    rr_clear_q();
    tick();
    rr_flush = 1'b0;
    rr_valid = '0;
    check("fl_wb_valid", rr_wbv, 0);
    check("fl_busy", rr_busy, 0);
    check("fl_in_ready", rr_rdy, 8'hFF);
    rr_wbr = 1'b1;
    repeat (4) begin
      tick();
      check("fl_no_ghost", rr_wbv, 0);
    end

    // async reset in the middle of a burst
    for (int i = 0; i < NCH; i++) rr_set(i, 5'(i), 32'h3000_0000 + 32'(i));
    tick();
    rr_valid = '0;
    tick();
    tick();
    check("ar_pre_valid", rr_wbv, 1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_wb_valid", rr_wbv, 0);
    check("ar_busy", rr_busy, 0);
    check("ar_in_ready", rr_rdy, 8'hFF);
    rr_clear_q();
    tick();
    tick();
    #3;
    reset = 1'b1;
    tick();
    rr_set(2, 5'd17, 32'hA5A5_0002);
    tick();
    rr_valid = '0;
    check("ar_lat1", rr_wbv, 0);
    tick();
    check("ar_lat2", rr_wbv, 1);
    check("ar_ch", rr_ch, 2);
    repeat (4) tick();
    check("end_rr_busy", rr_busy, 0);
    check("end_fx_busy", fx_busy, 0);

    left = 0;
    for (int i = 0; i < NCH; i++) left += rr_q[i].size() + fx_q[i].size();
    check("queues_drained", left, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
